fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer between the PC/branch logic and the instruction ROM; feeds IF_ID.
- Owns the fetch PC, issues word requests to the ROM (fixed 1-cycle read latency), buffers returned instructions in a small FIFO, and presents them to IF_ID with valid/stall flow control.
- Handles redirects (branch/jump/flush from the hazard detect unit) by discarding in-flight and buffered instructions.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, instruction buffer entries (power of two, >= 2).
- NOP_INST, 32'h0000_0000, value driven on inst_o when inst_valid_o=0 (matches DataBusReset).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall_i  in  1  hazard unit: IF_ID cannot accept this cycle.
- redirect_i  in  1  hazard/branch unit: discard and refetch from redirect_pc_i.
- redirect_pc_i  in  32  new fetch address; bits [1:0] ignored (forced 0).
- imem_req_o  out  1  ROM read request this cycle.
- imem_addr_o  out  32  byte address; ROM indexes addr[31:2].
- imem_rdata_i  in  32  ROM data, valid the cycle after imem_req_o=1.
- inst_valid_o  out  1  inst_o/inst_pc_o hold a real instruction.
- inst_o  out  32  instruction to IF_ID.
- inst_pc_o  out  32  PC of inst_o.

Behaviour:
- Reset (async assert, sync release): state=BOOT, pc=RESET_PC, FIFO empty, inflight=0, imem_req_o=0, imem_addr_o=RESET_PC, inst_valid_o=0, inst_o=NOP_INST, inst_pc_o=0.
- FSM:
  - BOOT: one cycle after reset release, no request; then RUN.
  - RUN: normal fetch.
  - REDIR: one cycle after a redirect; request issued at the new PC; then RUN.
- pop = inst_valid_o & ~stall_i & ~redirect_i.
- Issue rule (RUN/REDIR): imem_req_o=1 when occupancy + inflight - pop < DEPTH. On issue: imem_addr_o=pc, pc <= pc+4 (mod 2^32, wraps silently), inflight <= 1 for the next cycle.
- Response: cycle after an issue, {imem_rdata_i, issued pc} is pushed into the FIFO unless killed.
- Outputs: inst_valid_o = FIFO non-empty; inst_o/inst_pc_o = FIFO head, NOP_INST/0 when empty. Outputs are combinational from the FIFO registers; no ROM-to-output combinational path.
- Latency: request at cycle N, data in FIFO end of N+1, inst_valid_o at N+2.
- Throughput: 1 inst/cycle sustained with DEPTH=2 and no stall.
- Stall: head held stable (inst_o, inst_pc_o, inst_valid_o unchanged). Issue continues until the FIFO would fill. No overflow, no drop.
- Redirect (highest priority, wins over stall and pop):
  - Same edge: FIFO cleared, pc <= {redirect_pc_i[31:2],2'b00}, state <= REDIR.
  - Any response arriving next cycle (from an issue in the redirect cycle) is killed.
  - No request issued in the redirect cycle itself.
  - inst_valid_o=0 the cycle after redirect; first new inst valid two cycles after the REDIR request.
- Back-to-back redirects: latest target wins; each kills the prior in-flight response.
- Redirect during BOOT: accepted; pc takes the target, state -> REDIR.
- Reset mid-operation: all state cleared immediately (async); in-flight ROM data ignored.
- Invariant: occupancy + inflight <= DEPTH at all times. An assertion checks this.

Decomposition:
- Shared package/define: RESET_PC default, NOP encoding, FSM state encodings (BOOT/RUN/REDIR, 2-bit), DataSize width.
- One sub-module: fetch_fifo (DEPTH x 64-bit {pc,inst}, push/pop/clear, count, sync clear, async reset).

Test Plan:
- Reset release, no stall -> imem_addr_o 0x0,0x4,0x8 on cycles 1,2,3; inst_valid_o rises cycle 3 with inst_pc_o=0x0, then one inst per cycle.
- stall_i high 4 cycles at inst_pc_o=0x8 -> inst_o/inst_pc_o frozen at 0x8; at most 2 buffered (0x8,0xC); no request while full; release -> 0xC, 0x10 in order, none lost.
- redirect_i with redirect_pc_i=0x100 while 0x10 is in flight -> 0x10 and all buffered entries never appear; next valid inst_pc_o=0x100, then 0x104.
- redirect_i and stall_i asserted together, redirect_pc_i=0x203 -> redirect wins; fetch at 0x200; inst_pc_o=0x200.
- Two redirects on consecutive cycles (0x40, then 0x80) -> no inst from 0x40; first valid inst_pc_o=0x80.
- pc=0xFFFF_FFFC fetched -> next imem_addr_o=0x0000_0000; rst_n pulsed low mid-stream -> outputs return to reset values asynchronously, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

    localparam int          DATA_W       = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_DEF      = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_REDIR = 2'd2
    } fetch_state_e;

    // One buffered instruction together with the address it came from.
    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } fetch_entry_t;

    // Instruction addresses are word aligned; low bits are dropped.
    function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] a);
        return {a[DATA_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer of {pc, inst} entries with synchronous clear.
module fetch_fifo
    import fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    // Pointer/count update; clear drops everything and wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues ROM reads and
// buffers returned instructions for IF_ID with valid/stall flow control.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = NOP_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o
);

    localparam int           CW      = $clog2(DEPTH+1);
    localparam logic [CW:0]  DEPTH_W = (CW+1)'(DEPTH);

    fetch_state_e  state;
    logic [31:0]   pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  push_data;
    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   occ;

    assign inst_valid_o = (count != '0);
    assign pop          = inst_valid_o & ~stall_i & ~redirect_i;
    assign occ          = {1'b0, count} + {{CW{1'b0}}, inflight};

    // Only issue when the response is guaranteed a FIFO slot, counting the
    // slot freed by this cycle's pop. Never issue in BOOT or a redirect cycle.
    assign issue = (state != ST_BOOT) && !redirect_i &&
                   (occ < DEPTH_W + {{CW{1'b0}}, pop});

    // A response landing in a redirect cycle is stale; clear wins anyway,
    // but gating push keeps the intent explicit.
    assign push      = inflight & ~redirect_i;
    assign push_data = '{pc: inflight_pc, inst: imem_rdata_i};

    assign imem_req_o  = issue;
    assign imem_addr_o = pc;
    assign inst_o      = inst_valid_o ? head.inst : NOP_INST;
    assign inst_pc_o   = inst_valid_o ? head.pc   : '0;

    // Fetch FSM, PC and in-flight tracking; redirect takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_BOOT;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
                pc          <= pc + 32'd4;
            end
            if (redirect_i) begin
                pc    <= word_align(redirect_pc_i);
                state <= ST_REDIR;
            end else begin
                case (state)
                    ST_BOOT:  state <= ST_RUN;
                    ST_REDIR: state <= ST_RUN;
                    default:  state <= ST_RUN;
                endcase
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (redirect_i),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    // Buffered plus outstanding instructions never exceed the buffer size.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) occ <= DEPTH_W)
        else $error("fetch buffer occupancy exceeded");

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed timing checks plus a randomized run against
// an in-order instruction-stream scoreboard.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] rdata = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int tests    = 0;
    int fails    = 0;
    int accepted = 0;

    logic [31:0] exp_q[$];
    logic [31:0] nxt;
    logic [31:0] mon_e;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_i      (stall),
        .redirect_i   (redirect),
        .redirect_pc_i(rpc),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_rdata_i (rdata),
        .inst_valid_o (inst_valid),
        .inst_o       (inst),
        .inst_pc_o    (inst_pc)
    );

    // ROM contents are a fixed hash of the address.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // ROM with one-cycle read latency.
    always @(posedge clk) if (imem_req) rdata <= rom(imem_addr);

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Expected stream: sequential word addresses from the latest fetch start.
    task automatic topup();
        while (exp_q.size() < 8) begin
            exp_q.push_back(nxt);
            nxt = nxt + 32'd4;
        end
    endtask

    task automatic sb_reset(input logic [31:0] t);
        exp_q.delete();
        nxt = t & 32'hFFFF_FFFC;
        topup();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        topup();
    endtask

    // Monitor: every accepted instruction must be the next one of the stream.
    logic        pv = 1'b0;
    logic        ps, pr;
    logic [31:0] ppc, pinst;
    always @(negedge clk) begin
        if (rst_n) begin
            if (pv && ps && !pr) begin
                chk("stall_hold_valid", 32'(inst_valid), 32'd1);
                chk("stall_hold_pc", inst_pc, ppc);
                chk("stall_hold_inst", inst, pinst);
            end
            if (inst_valid && !stall && !redirect) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_empty: got pc %h expected none", inst_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pop_pc", inst_pc, mon_e);
                    chk("pop_inst", inst, rom(mon_e));
                    accepted++;
                end
            end
            if (!inst_valid) begin
                chk("idle_inst", inst, 32'h0);
                chk("idle_pc", inst_pc, 32'h0);
            end
            pv    <= inst_valid;
            ps    <= stall;
            pr    <= redirect;
            ppc   <= inst_pc;
            pinst <= inst;
        end else begin
            pv <= 1'b0;
        end
    end

    // Single redirect followed by the fixed refetch timeline.
    task automatic redir_chk(input logic [31:0] target, input logic s);
        logic [31:0] al;
        al = target & 32'hFFFF_FFFC;
        tick();
        redirect = 1'b1;
        rpc      = target;
        stall    = s;
        sb_reset(target);
        @(negedge clk);
        chk("redir_cycle_req", 32'(imem_req), 32'd0);
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        @(negedge clk);
        chk("redir_valid0", 32'(inst_valid), 32'd0);
        chk("redir_req", 32'(imem_req), 32'd1);
        chk("redir_addr", imem_addr, al);
        tick();
        @(negedge clk);
        chk("redir_valid1", 32'(inst_valid), 32'd0);
        chk("redir_addr2", imem_addr, al + 32'd4);
        tick();
        @(negedge clk);
        chk("redir_first_valid", 32'(inst_valid), 32'd1);
        chk("redir_first_pc", inst_pc, al);
        tick();
        @(negedge clk);
        chk("redir_second_pc", inst_pc, al + 32'd4);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        bit got_valid;
        rst_n    = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        rpc      = '0;
        sb_reset(32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);

        // Release; cycle 0 is BOOT, fetch starts on cycle 1.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_reset(32'h0);
        @(negedge clk);
        chk("boot_req", 32'(imem_req), 32'd0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            @(negedge clk);
            chk("start_req", 32'(imem_req), 32'd1);
            chk("start_addr", imem_addr, 32'(4*(c-1)));
            chk("start_valid", 32'(inst_valid), 32'(c == 3));
        end
        chk("first_pc", inst_pc, 32'h0);
        tick();
        @(negedge clk);
        chk("head_4", inst_pc, 32'h4);

        // Stall four cycles with 0x8 at the head.
        tick();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_pc", inst_pc, 32'h8);
            chk("stall_req", 32'(imem_req), 32'd0);
            tick();
        end
        stall = 1'b0;
        @(negedge clk);
        chk("unstall_pc", inst_pc, 32'h8);
        chk("unstall_req", 32'(imem_req), 32'd1);
        chk("unstall_addr", imem_addr, 32'h10);
        tick();
        @(negedge clk);
        chk("after_stall_c", inst_pc, 32'hC);
        tick();
        @(negedge clk);
        chk("after_stall_10", inst_pc, 32'h10);

        redir_chk(32'h100, 1'b0);
        redir_chk(32'h203, 1'b1);

        // Back-to-back redirects: only the second target survives.
        tick();
        redirect = 1'b1;
        rpc      = 32'h40;
        sb_reset(32'h40);
        tick();
        rpc = 32'h80;
        sb_reset(32'h80);
        @(negedge clk);
        chk("b2b_req", 32'(imem_req), 32'd0);
        tick();
        redirect = 1'b0;
        @(negedge clk);
        chk("b2b_addr", imem_addr, 32'h80);
        got_valid = 1'b0;
        for (int i = 0; i < 10 && !got_valid; i++) begin
            tick();
            @(negedge clk);
            got_valid = inst_valid;
        end
        chk("b2b_valid_in_time", 32'(got_valid), 32'd1);
        chk("b2b_first_pc", inst_pc, 32'h80);

        // PC wrap at the top of the address space.
        redir_chk(32'hFFFF_FFFC, 1'b0);

        // Asynchronous reset mid-stream.
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(inst_valid), 32'd0);
        chk("arst_inst", inst, 32'h0);
        chk("arst_pc", inst_pc, 32'h0);
        chk("arst_req", 32'(imem_req), 32'd0);
        chk("arst_addr", imem_addr, 32'h0);
        tick();
        rst_n = 1'b1;
        sb_reset(32'h0);
        @(negedge clk);
        chk("arst_boot_req", 32'(imem_req), 32'd0);
        tick();
        @(negedge clk);
        chk("arst_restart_req", 32'(imem_req), 32'd1);
        chk("arst_restart_addr", imem_addr, 32'h0);

        // Randomized stall/redirect traffic.
        for (int i = 0; i < 3000; i++) begin
            tick();
            stall    = ($urandom_range(0, 99) < 30);
            redirect = ($urandom_range(0, 99) < 4);
            if (redirect) begin
                if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                else                           rpc = $urandom & 32'h0000_FFFF;
                sb_reset(rpc);
            end
        end
        tick();
        stall    = 1'b0;
        redirect = 1'b0;
        repeat (10) tick();
        chk("accepted_min", 32'(accepted > 1000), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
